// File: rtl/rc5_job_sched.sv
// Job scheduler for the RC5 cipher/decipher engines: one block job at a time, engine clear/start,
// done-lag wait, result handshake and shared S-table address mux. Optional watchdog: RC5_TIMEOUT_EN.
module rc5_job_sched #(
    parameter int W        = 32,
    parameter int R        = 12,
    parameter int DONE_LAG = 2,
    parameter int TIMEOUT  = 1023,
    parameter int T_LENGTH = $clog2(2 * (R + 1))
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iValid,
    output logic                oReady,
    input  logic                iMode,
    input  logic [W-1:0]        iA,
    input  logic [W-1:0]        iB,
    output logic                oValid,
    input  logic                iReady,
    output logic [W-1:0]        oA,
    output logic [W-1:0]        oB,
    output logic                oMode,
    output logic                oErr,
    output logic                oEngRst,
    output logic                oCipStart,
    output logic                oDecStart,
    output logic [W-1:0]        oEngA,
    output logic [W-1:0]        oEngB,
    input  logic                iCipDone,
    input  logic                iDecDone,
    input  logic [W-1:0]        iCipA,
    input  logic [W-1:0]        iCipB,
    input  logic [W-1:0]        iDecA,
    input  logic [W-1:0]        iDecB,
    input  logic [T_LENGTH-1:0] iCipAddr1,
    input  logic [T_LENGTH-1:0] iCipAddr2,
    input  logic [T_LENGTH-1:0] iDecAddr1,
    input  logic [T_LENGTH-1:0] iDecAddr2,
    output logic [T_LENGTH-1:0] oSAddr1,
    output logic [T_LENGTH-1:0] oSAddr2
);

    typedef enum logic [2:0] {IDLE, CLR, START, BUSY, LAG, RESP} state_t;

    localparam int LAG_W = (DONE_LAG < 1) ? 1 : $clog2(DONE_LAG + 1);

    state_t             state, state_next;
    logic               r_mode;
    logic [LAG_W-1:0]   lag_cnt;
    logic               sel_done;
    logic               lag_last;
    logic               timeout_hit;
    logic [W-1:0]       sel_a, sel_b;

    assign sel_done = r_mode ? iDecDone : iCipDone;
    assign sel_a    = r_mode ? iDecA : iCipA;
    assign sel_b    = r_mode ? iDecB : iCipB;
    // The counter is checked before its decrement lands, so a value of 1 means the lag ends this cycle.
    assign lag_last = (lag_cnt <= LAG_W'(1));

    assign oReady    = (state == IDLE) & rst;
    assign oEngRst   = ~rst | (state == CLR);
    assign oCipStart = (state == START) & ~r_mode;
    assign oDecStart = (state == START) & r_mode;
    assign oValid    = (state == RESP);
    assign oMode     = r_mode;
    assign oSAddr1   = r_mode ? iDecAddr1 : iCipAddr1;
    assign oSAddr2   = r_mode ? iDecAddr2 : iCipAddr2;

`ifdef RC5_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));
    assign oErr        = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == START)
                to_cnt <= '0;
            else if (state == BUSY)
                to_cnt <= to_cnt + TO_W'(1);
            if (state == BUSY && !sel_done && timeout_hit)
                err_q <= 1'b1;
            else if (state == LAG && lag_last)
                err_q <= 1'b0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign oErr           = 1'b0;
`endif

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: state_next gets its default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (iValid) state_next = CLR;
            CLR:     state_next = START;
            START:   state_next = BUSY;
            BUSY: begin
                if (sel_done)
                    state_next = LAG;
                else if (timeout_hit)
                    state_next = RESP;
            end
            LAG:     if (lag_last) state_next = RESP;
            RESP:    if (iReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, so outputs read 0 during reset rather than holding stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode  <= 1'b0;
            oEngA   <= '0;
            oEngB   <= '0;
            oA      <= '0;
            oB      <= '0;
            lag_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iValid) begin
                        r_mode <= iMode;
                        oEngA  <= iA;
                        oEngB  <= iB;
                    end
                end
                BUSY: begin
                    if (sel_done) begin
                        lag_cnt <= LAG_W'(DONE_LAG);
                    end else if (timeout_hit) begin
                        oA <= '0;
                        oB <= '0;
                    end
                end
                LAG: begin
                    if (lag_cnt != '0)
                        lag_cnt <= lag_cnt - LAG_W'(1);
                    if (lag_last) begin
                        oA <= sel_a;
                        oB <= sel_b;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
